// File: rtl/legv8_pkg.sv
// ---------------------------------------------------------------------------
// legv8_pkg : shared LEGv8 control constants (states, opcodes, mux selects)
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package legv8_pkg;

  typedef enum logic [3:0] {
    st_rst       = 4'd0,
    st_fetch     = 4'd1,
    st_decode    = 4'd2,
    st_mem_addr  = 4'd3,
    st_mem_read  = 4'd4,
    st_mem_wb    = 4'd5,
    st_mem_write = 4'd6,
    st_exec_r    = 4'd7,
    st_r_wb      = 4'd8,
    st_br_cbz    = 4'd9,
    st_br_b      = 4'd10,
    st_halt      = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    cls_mem_ld  = 3'd0,
    cls_mem_st  = 3'd1,
    cls_rtype   = 3'd2,
    cls_cbz     = 3'd3,
    cls_b       = 3'd4,
    cls_illegal = 3'd5
  } instr_class_t;

  localparam logic [10:0] c_op_ldur = 11'b11111000010;
  localparam logic [10:0] c_op_stur = 11'b11111000000;
  localparam logic [10:0] c_op_add  = 11'b10001011000;
  localparam logic [10:0] c_op_sub  = 11'b11001011000;
  localparam logic [10:0] c_op_and  = 11'b10001010000;
  localparam logic [10:0] c_op_orr  = 11'b10101010000;

  // CBZ and B carry register/offset bits in the low opcode field
  localparam logic [10:0] c_op_cbz_mask  = 11'b11111111000;
  localparam logic [10:0] c_op_cbz_match = 11'b10110100000;
  localparam logic [10:0] c_op_b_mask    = 11'b11111100000;
  localparam logic [10:0] c_op_b_match   = 11'b00010100000;

  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_passb = 2'b01;
  localparam logic [1:0] c_aluop_rtype = 2'b10;

  localparam logic [1:0] c_srcb_reg  = 2'b00;
  localparam logic [1:0] c_srcb_four = 2'b01;
  localparam logic [1:0] c_srcb_dofs = 2'b10;
  localparam logic [1:0] c_srcb_bofs = 2'b11;

  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_btgt   = 2'b10;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] mask,
                                    input logic [10:0] match);
    return (op & mask) == match;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_decode.sv
// ---------------------------------------------------------------------------
// multicycle_control_decode : opcode -> instruction class map
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control_decode
  import legv8_pkg::*;
#(
  parameter int OPCODE_W = 11
) (
  input  logic [OPCODE_W-1:0] opcode,
  output instr_class_t        iclass
);

  logic [10:0] w_op;

  assign w_op = opcode[OPCODE_W-1 -: 11];

  always_comb begin
    iclass = cls_illegal;
    if (w_op == c_op_ldur) begin
      iclass = cls_mem_ld;
    end else if (w_op == c_op_stur) begin
      iclass = cls_mem_st;
    end else if ((w_op == c_op_add) || (w_op == c_op_sub) ||
                 (w_op == c_op_and) || (w_op == c_op_orr)) begin
      iclass = cls_rtype;
    end else if (op_match(w_op, c_op_cbz_mask, c_op_cbz_match)) begin
      iclass = cls_cbz;
    end else if (op_match(w_op, c_op_b_mask, c_op_b_match)) begin
      iclass = cls_b;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control : LEGv8 multi-cycle main control FSM
// Option macro MULTICYCLE_CONTROL_INSTR_COUNT_EN adds the InstrCount output.
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control
  import legv8_pkg::*;
#(
  parameter int OPCODE_W     = 11,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  input  logic                MemReady,
  output logic [1:0]          ALUOp,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic                PCEn,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemToReg,
  output logic                RegWrite,
  output logic                Reg2Loc,
  output logic                IllegalOp,
  output logic [3:0]          State
`ifdef MULTICYCLE_CONTROL_INSTR_COUNT_EN
  ,
  output logic [31:0]         InstrCount
`endif
);

  state_t       r_state;
  state_t       w_next;
  instr_class_t w_class;

  multicycle_control_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .opcode (Opcode),
    .iclass (w_class)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= st_rst;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    ALUOp     = c_aluop_add;
    ALUSrcA   = 1'b0;
    ALUSrcB   = c_srcb_reg;
    PCSource  = c_pcsrc_alu;
    PCEn      = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    MemToReg  = 1'b0;
    RegWrite  = 1'b0;
    Reg2Loc   = 1'b0;
    IllegalOp = 1'b0;

    case (r_state)
      st_rst: begin
        w_next = st_fetch;
      end
      st_fetch: begin
        MemRead = 1'b1;
        ALUSrcB = c_srcb_four;
        PCEn    = MemReady;
        IRWrite = MemReady;
        if (MemReady) begin
          w_next = st_decode;
        end
      end
      st_decode: begin
        // ALU precomputes the branch target while the opcode is classified
        ALUSrcB = c_srcb_bofs;
        case (w_class)
          cls_mem_ld, cls_mem_st: w_next = st_mem_addr;
          cls_rtype:              w_next = st_exec_r;
          cls_cbz:                w_next = st_br_cbz;
          cls_b:                  w_next = st_br_b;
          default: begin
            IllegalOp = 1'b1;
            w_next    = (ILLEGAL_HALT != 1'b0) ? st_halt : st_fetch;
          end
        endcase
      end
      st_mem_addr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = c_srcb_dofs;
        if (w_class == cls_mem_st) begin
          w_next = st_mem_write;
        end else if (w_class == cls_mem_ld) begin
          w_next = st_mem_read;
        end else begin
          w_next = st_fetch;
        end
      end
      st_mem_read: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (MemReady) begin
          w_next = st_mem_wb;
        end
      end
      st_mem_wb: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        w_next   = st_fetch;
      end
      st_mem_write: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) begin
          w_next = st_fetch;
        end
      end
      st_exec_r: begin
        ALUSrcA = 1'b1;
        ALUOp   = c_aluop_rtype;
        w_next  = st_r_wb;
      end
      st_r_wb: begin
        RegWrite = 1'b1;
        w_next   = st_fetch;
      end
      st_br_cbz: begin
        ALUSrcA  = 1'b1;
        ALUOp    = c_aluop_passb;
        PCSource = c_pcsrc_aluout;
        PCEn     = Zero;
        w_next   = st_fetch;
      end
      st_br_b: begin
        PCSource = c_pcsrc_btgt;
        PCEn     = 1'b1;
        w_next   = st_fetch;
      end
      st_halt: begin
        w_next = st_halt;
      end
      default: begin
        w_next = st_fetch;
      end
    endcase

    // Rt feeds read port 2 for STUR data and the CBZ test register
    if ((r_state != st_rst) && (r_state != st_halt) &&
        ((w_class == cls_mem_st) || (w_class == cls_cbz))) begin
      Reg2Loc = 1'b1;
    end
  end

  assign State = r_state;

`ifdef MULTICYCLE_CONTROL_INSTR_COUNT_EN
  logic        w_retire;
  logic [31:0] r_instr_count;

  // An instruction retires on its final transition back into FETCH
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      st_mem_wb, st_r_wb, st_br_cbz, st_br_b: w_retire = 1'b1;
      st_mem_write:                            w_retire = MemReady;
      default:                                 w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_count <= 32'd0;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign InstrCount = r_instr_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control : directed + randomized bench with instruction-level
// reference model; two DUTs share stimulus (ILLEGAL_HALT = 0 and 1).
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b1;
  logic [10:0] Opcode = 11'b0;
  logic        armed = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic [1:0] aluop_a, srcb_a, pcs_a, aluop_h, srcb_h, pcs_h;
  logic srca_a, pcen_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rw_a, r2l_a, ill_a;
  logic srca_h, pcen_h, iord_h, mrd_h, mwr_h, irw_h, m2r_h, rw_h, r2l_h, ill_h;
  logic [3:0] state_a, state_h;
  logic [15:0] got_a, got_h;
`ifdef MULTICYCLE_CONTROL_INSTR_COUNT_EN
  logic [31:0] icnt_a, icnt_h;
`endif

  assign got_a = {aluop_a, srca_a, srcb_a, pcs_a, pcen_a, iord_a, mrd_a, mwr_a,
                  irw_a, m2r_a, rw_a, r2l_a, ill_a};
  assign got_h = {aluop_h, srca_h, srcb_h, pcs_h, pcen_h, iord_h, mrd_h, mwr_h,
                  irw_h, m2r_h, rw_h, r2l_h, ill_h};

  multicycle_control #(.OPCODE_W(11), .ILLEGAL_HALT(1'b0)) u_dut_a (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .ALUOp(aluop_a), .ALUSrcA(srca_a), .ALUSrcB(srcb_a), .PCSource(pcs_a),
    .PCEn(pcen_a), .IorD(iord_a), .MemRead(mrd_a), .MemWrite(mwr_a),
    .IRWrite(irw_a), .MemToReg(m2r_a), .RegWrite(rw_a), .Reg2Loc(r2l_a),
    .IllegalOp(ill_a), .State(state_a)
`ifdef MULTICYCLE_CONTROL_INSTR_COUNT_EN
    , .InstrCount(icnt_a)
`endif
  );

  multicycle_control #(.OPCODE_W(11), .ILLEGAL_HALT(1'b1)) u_dut_h (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .ALUOp(aluop_h), .ALUSrcA(srca_h), .ALUSrcB(srcb_h), .PCSource(pcs_h),
    .PCEn(pcen_h), .IorD(iord_h), .MemRead(mrd_h), .MemWrite(mwr_h),
    .IRWrite(irw_h), .MemToReg(m2r_h), .RegWrite(rw_h), .Reg2Loc(r2l_h),
    .IllegalOp(ill_h), .State(state_h)
`ifdef MULTICYCLE_CONTROL_INSTR_COUNT_EN
    , .InstrCount(icnt_h)
`endif
  );

  // ---------------- reference model: instructions as phase lists ----------
  typedef enum int {P_RST, P_FETCH, P_DECODE, P_ADDR, P_RD, P_MWB, P_WR,
                    P_EX, P_RWB, P_CBZ, P_B, P_HALT} ph_t;
  localparam int C_LD = 0, C_ST = 1, C_R = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

  ph_t         mph [2];
  int          mpi [2];
  int          mcls[2];
  logic [31:0] mcnt[2];

  function automatic int cls(input logic [10:0] op);
    if (op == 11'b11111000010) return C_LD;
    if (op == 11'b11111000000) return C_ST;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return C_R;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op[10:5] == 6'b000101) return C_B;
    return C_ILL;
  endfunction

  // Phases an instruction runs after DECODE; past the end it is back in FETCH
  function automatic ph_t plan_at(input int c, input int idx);
    case (c)
      C_LD:  case (idx) 0: return P_ADDR; 1: return P_RD; 2: return P_MWB; default: return P_FETCH; endcase
      C_ST:  case (idx) 0: return P_ADDR; 1: return P_WR; default: return P_FETCH; endcase
      C_R:   case (idx) 0: return P_EX; 1: return P_RWB; default: return P_FETCH; endcase
      C_CBZ: return (idx == 0) ? P_CBZ : P_FETCH;
      C_B:   return (idx == 0) ? P_B : P_FETCH;
      default: return P_FETCH;
    endcase
  endfunction

  function automatic logic [15:0] expect_out(input ph_t p, input logic mr,
                                             input logic z, input logic [10:0] op);
    logic [1:0] aluop, srcb, pcs;
    logic srca, pcen, iord, mrd, mwr, irw, m2r, rw, r2l, ill;
    int c;
    c = cls(op);
    aluop = 2'b00; srcb = 2'b00; pcs = 2'b00;
    srca = 0; pcen = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0; rw = 0; ill = 0;
    case (p)
      P_FETCH:  begin mrd = 1; srcb = 2'b01; pcen = mr; irw = mr; end
      P_DECODE: begin srcb = 2'b11; ill = (c == C_ILL); end
      P_ADDR:   begin srca = 1; srcb = 2'b10; end
      P_RD:     begin iord = 1; mrd = 1; end
      P_MWB:    begin rw = 1; m2r = 1; end
      P_WR:     begin iord = 1; mwr = 1; end
      P_EX:     begin srca = 1; aluop = 2'b10; end
      P_RWB:    begin rw = 1; end
      P_CBZ:    begin srca = 1; aluop = 2'b01; pcs = 2'b01; pcen = z; end
      P_B:      begin pcs = 2'b10; pcen = 1; end
      default:  begin end
    endcase
    r2l = (p != P_RST) && (p != P_HALT) && (c == C_ST || c == C_CBZ);
    return {aluop, srca, srcb, pcs, pcen, iord, mrd, mwr, irw, m2r, rw, r2l, ill};
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mph[i]  <= P_RST;
        mpi[i]  <= 0;
        mcls[i] <= C_ILL;
        mcnt[i] <= 32'd0;
      end else begin
        case (mph[i])
          P_RST:   mph[i] <= P_FETCH;
          P_HALT:  mph[i] <= P_HALT;
          P_FETCH: if (MemReady) mph[i] <= P_DECODE;
          P_DECODE: begin
            mcls[i] <= cls(Opcode);
            mpi[i]  <= 1;
            if (cls(Opcode) == C_ILL) mph[i] <= (i == 1) ? P_HALT : P_FETCH;
            else                      mph[i] <= plan_at(cls(Opcode), 0);
          end
          default: begin
            if (!((mph[i] == P_RD || mph[i] == P_WR) && !MemReady)) begin
              mph[i] <= plan_at(mcls[i], mpi[i]);
              mpi[i] <= mpi[i] + 1;
              if (plan_at(mcls[i], mpi[i]) == P_FETCH) mcnt[i] <= mcnt[i] + 32'd1;
            end
          end
        endcase
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("model_out_a", 32'(got_a), 32'(expect_out(mph[0], MemReady, Zero, Opcode)));
      check("model_out_h", 32'(got_h), 32'(expect_out(mph[1], MemReady, Zero, Opcode)));
      check("state_rst_a", 32'(state_a == 4'd0), 32'(mph[0] == P_RST));
      check("state_rst_h", 32'(state_h == 4'd0), 32'(mph[1] == P_RST));
`ifdef MULTICYCLE_CONTROL_INSTR_COUNT_EN
      check("icount_a", icnt_a, mcnt[0]);
      check("icount_h", icnt_h, mcnt[1]);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1; MemReady = 1'b1; Zero = 1'b0; Opcode = 11'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_state", 32'(state_a), 32'd0);
    check("rst_outputs", 32'(got_a), 32'd0);
    @(negedge clk); #1;
    check("fetch_outputs", 32'(got_a), 32'(16'b00_0_01_00_1_0_1_0_1_0_0_0_0));
  endtask

  // Entered while instance a is in FETCH; returns when it is next in FETCH
  task automatic run_instr(input logic [10:0] op, input logic z, input int waits,
                           output int cycles, output int n_mem, output int n_ill,
                           output int n_ill_h, output logic saw_pcen, output logic saw_r2l);
    int w;
    w = waits;
    Opcode = op; Zero = z; MemReady = 1'b1;
    cycles = 1; n_mem = 0; n_ill = 0; n_ill_h = 0; saw_pcen = 1'b0; saw_r2l = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (mrd_a && !iord_a) return;
      cycles++;
      if (ill_a) n_ill++;
      if (ill_h) n_ill_h++;
      if (aluop_a == 2'b01) saw_pcen = pcen_a;
      if (srcb_a == 2'b10 && waits > 0) MemReady = 1'b0;
      if (iord_a) begin
        n_mem++;
        if (mwr_a) saw_r2l = r2l_a;
        if (w == 0) MemReady = 1'b1;
        else w--;
      end
    end
    checks++; failures++;
    $display("FAIL instr_timeout: op 0x%0h did not return to fetch", op);
  endtask

  function automatic logic [10:0] rand_op();
    logic [10:0] r;
    r = 11'($urandom);
    case ($urandom_range(0, 8))
      0: return 11'b11111000010;
      1: return 11'b11111000000;
      2: return 11'b10001011000;
      3: return 11'b11001011000;
      4: return 11'b10001010000;
      5: return 11'b10101010000;
      6: return {8'b10110100, r[2:0]};
      7: return {6'b000101, r[4:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    int cyc, nmem, nill, nillh;
    logic pc, r2;
    @(posedge clk);
    armed = 1'b1;
    do_reset();

    run_instr(11'b10001011000, 1'b0, 0, cyc, nmem, nill, nillh, pc, r2);
    check("add_cycles", cyc, 4);
    run_instr(11'b11111000010, 1'b0, 3, cyc, nmem, nill, nillh, pc, r2);
    check("ldur_memread_cycles", nmem, 4);
    check("ldur_cycles", cyc, 8);
    run_instr(11'b11111000000, 1'b0, 0, cyc, nmem, nill, nillh, pc, r2);
    check("stur_cycles", cyc, 4);
    check("stur_reg2loc", 32'(r2), 1);
    run_instr(11'b10110100000, 1'b1, 0, cyc, nmem, nill, nillh, pc, r2);
    check("cbz_taken_pcen", 32'(pc), 1);
    check("cbz_cycles", cyc, 3);
    run_instr(11'b10110100000, 1'b0, 0, cyc, nmem, nill, nillh, pc, r2);
    check("cbz_not_taken_pcen", 32'(pc), 0);
    run_instr(11'b00010111111, 1'b0, 0, cyc, nmem, nill, nillh, pc, r2);
    check("b_cycles", cyc, 3);
    run_instr(11'b00000000000, 1'b0, 0, cyc, nmem, nill, nillh, pc, r2);
    check("illegal_cycles", cyc, 2);
    check("illegal_pulse_a", nill, 1);
    check("illegal_pulse_h", nillh, 1);
    run_instr(11'b10001011000, 1'b0, 0, cyc, nmem, nill, nillh, pc, r2);
    check("halt_outputs", 32'(got_h), 0);
    check("halt_state_nonzero", 32'(state_h != 4'd0), 1);

    // Reset in the middle of a store, between clock edges
    Opcode = 11'b11111000000; Zero = 1'b0; MemReady = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (srcb_a == 2'b10) MemReady = 1'b0;
      if (mwr_a) break;
    end
    check("reach_mem_write", 32'(mwr_a), 1);
    #1 reset = 1'b1;
    #1;
    check("memwrite_async_drop", 32'(mwr_a), 0);
    check("state_async_zero", 32'(state_a), 0);
    @(negedge clk); #1;
    reset = 1'b0; MemReady = 1'b1;
    @(negedge clk); #1;
`ifdef MULTICYCLE_CONTROL_INSTR_COUNT_EN
    check("icount_after_reset", icnt_a, 0);
    run_instr(11'b10001011000, 1'b0, 0, cyc, nmem, nill, nillh, pc, r2);
    run_instr(11'b00010100001, 1'b0, 0, cyc, nmem, nill, nillh, pc, r2);
    run_instr(11'b11111000000, 1'b0, 0, cyc, nmem, nill, nillh, pc, r2);
    check("icount_three", icnt_a, 3);
`endif

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      if (mph[0] == P_FETCH && $urandom_range(0, 1) == 1) Opcode = rand_op();
      MemReady = ($urandom_range(0, 3) != 0);
      Zero     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end

    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle LEGv8 datapath. It is the producer of the 2-bit ALUOp consumed by the ALU control decoder. From the 11-bit IR opcode it sequences fetch, decode, execute, memory and writeback, and drives every datapath mux select and enable. Memory accesses use a MemReady wait handshake.

Parameters:
- OPCODE_W, 11: instruction opcode field width (IR[31:21]).
- ILLEGAL_HALT, 0: 0 = an illegal opcode returns to FETCH; 1 = it enters HALT until reset.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- Opcode  in  OPCODE_W  IR[31:21]; held stable by the IR after FETCH.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory has completed the current access.
- ALUOp  out  2  00 = add, 01 = pass-B (CBZ), 10 = R-type (funct from opcode).
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = reg B, 01 = const 4, 10 = D-offset sign-extended, 11 = branch offset <<2.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = B-target.
- PCEn  out  1  PC write enable.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemToReg  out  1  write-back data select; 1 = MDR.
- RegWrite  out  1  register file write enable.
- Reg2Loc  out  1  read-register-2 select; 1 = Rt.
- IllegalOp  out  1  one-cycle pulse on an undecodable opcode.
- State  out  4  current state, for debug.

Behaviour:
- Reset value of all outputs is 0 in every case.
  - States: RST, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, BR_CBZ, BR_B, HALT.
  - Async reset forces RST; State = 0. RST goes to FETCH on the next edge.
  - Reset mid-instruction abandons the instruction with no further writes.
- Outputs are Moore-decoded from the state unless noted. Anything not listed is 0.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - PCEn = IRWrite = MemReady.
  - Stays in FETCH while MemReady=0; moves to DECODE when MemReady=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by opcode:
    - LDUR 11111000010 / STUR 11111000000 -> MEM_ADDR.
    - ADD 10001011000 / SUB 11001011000 / AND 10001010000 / ORR 10101010000 -> EXEC_R.
    - CBZ 10110100xxx -> BR_CBZ.
    - B 000101xxxxx -> BR_B.
    - Anything else: IllegalOp=1 this cycle, next state FETCH (or HALT if ILLEGAL_HALT=1).
- MEM_ADDR:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state is MEM_READ for LDUR, MEM_WRITE for STUR.
- MEM_READ: drives IorD=1, MemRead=1. Waits until MemReady=1, then goes to MEM_WB.
- MEM_WB: drives RegWrite=1, MemToReg=1. Next state FETCH.
- MEM_WRITE: drives IorD=1, MemWrite=1. Waits until MemReady=1, then goes to FETCH.
- EXEC_R: drives ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state R_WB.
- R_WB: drives RegWrite=1, MemToReg=0. Next state FETCH.
- BR_CBZ:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01.
  - PCEn = Zero (Mealy). Next state FETCH.
- BR_B: drives PCSource=10, PCEn=1. Next state FETCH.
- HALT: all outputs 0. Leaves only on reset.
- Reg2Loc = 1 combinationally whenever Opcode matches STUR or CBZ, in any state except RST.
- Cycle counts with MemReady tied high: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3.
- MemReady is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Unused state encodings go to FETCH.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_INSTR_COUNT_EN.
- Defined:
  - Adds output InstrCount [31:0], reset to 0.
  - Increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BR_CBZ or BR_B.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package legv8_pkg holds:
  - state enum constants;
  - opcode constants: LDUR, STUR, ADD, SUB, AND, ORR, plus CBZ and B match masks;
  - ALUOp codes 00, 01, 10;
  - ALUSrcB and PCSource select constants.
- The ALU control decoder reuses these constants.
- One natural sub-module, multicycle_control_decode: combinational map from opcode to instruction class (MEM_LD, MEM_ST, RTYPE, CBZ, B, ILLEGAL) used by DECODE and Reg2Loc.

Test Plan:
- Reset released, MemReady=1 -> one cycle in RST with all outputs 0, then FETCH with MemRead=1, PCEn=1, IRWrite=1, ALUSrcB=01.
- ADD 10001011000 -> states FETCH, DECODE, EXEC_R (ALUOp=10), R_WB (RegWrite=1); back in FETCH at cycle 4.
- LDUR with MemReady low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles, then MEM_WB (MemToReg=1, RegWrite=1); STUR -> MemWrite=1 with Reg2Loc=1.
- CBZ 10110100000, Zero=1 -> PCEn=1, PCSource=01, ALUOp=01; repeat with Zero=0 -> PCEn=0, next state FETCH.
- Opcode 00000000000 -> IllegalOp pulses exactly one cycle in DECODE; ILLEGAL_HALT=0 -> FETCH; ILLEGAL_HALT=1 -> HALT holds until reset.
- Reset asserted mid-MEM_WRITE -> MemWrite drops immediately (asynchronously) and State=0; with the macro defined, InstrCount=0 after reset and reads 3 after ADD, B, STUR complete.
